// File: rtl/sine_pkg.sv
// Shared types and defaults for the sine-table ROM read sequencer.
// Holds the FSM state encoding, default widths and the address-width helper.
package sine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } sine_state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_PHASE_W = 16;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// Phase accumulator, tuning register and phase-to-address mapping.
// Ports: clear/step/load_tune controls, tuning_word in; addr_nxt/neg_nxt
// give the ROM address and negate flag for the phase of the next cycle.
// Macro SINE_QUARTER_WAVE_EN selects quarter-table mirroring and negation.
module sine_phase_acc
    import sine_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      step,
    input  logic                      load_tune,
    input  logic [PHASE_W-1:0]        tuning_word,
    output logic [addr_w(DEPTH)-1:0]  addr_nxt,
    output logic                      neg_nxt
);

    localparam int AW = addr_w(DEPTH);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] tune_q, tune_d;

    // Carry-out is dropped so the address wraps seamlessly.
    always_comb begin
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (step) begin
            phase_d = phase_q + tune_q;
        end
        tune_d = load_tune ? tuning_word : tune_q;
    end

    // Address is taken from the next-cycle phase so it can be
    // registered on the same edge that enters FETCH.
`ifdef SINE_QUARTER_WAVE_EN
    logic [1:0]    quad;
    logic [AW-1:0] idx;

    always_comb begin
        quad     = phase_d[PHASE_W-1 -: 2];
        idx      = phase_d[PHASE_W-3 -: AW];
        // DEPTH is a power of two, so DEPTH-1-idx is the bitwise inverse.
        addr_nxt = quad[0] ? ~idx : idx;
        neg_nxt  = quad[1];
    end
`else
    always_comb begin
        addr_nxt = phase_d[PHASE_W-1 -: AW];
        neg_nxt  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            tune_q  <= '0;
        end else begin
            phase_q <= phase_d;
            tune_q  <= tune_d;
        end
    end

endmodule

// File: rtl/sine_rom_sequencer.sv
// DDS-style read controller for a synchronous sine ROM with valid/ready output.
// Ports: clk, rst_n, start, stop, tuning_word; rom_en/rom_address/rom_data to
// the ROM; sample/sample_valid/sample_ready downstream; busy when not IDLE.
// Macro SINE_QUARTER_WAVE_EN (in sine_phase_acc) enables quarter-wave tables.
module sine_rom_sequencer
    import sine_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic [PHASE_W-1:0]        tuning_word,
    output logic                      rom_en,
    output logic [addr_w(DEPTH)-1:0]  rom_address,
    input  logic [WIDTH-1:0]          rom_data,
    output logic [WIDTH-1:0]          sample,
    output logic                      sample_valid,
    input  logic                      sample_ready,
    output logic                      busy
);

    localparam int AW = addr_w(DEPTH);

    sine_state_e      state_q, state_d;
    logic             rom_en_q, rom_en_d;
    logic [AW-1:0]    rom_address_q, rom_address_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             stop_pend_q, stop_pend_d;
    logic             neg_q, neg_d;
    logic             busy_q, busy_d;

    logic             clear, step, load_tune, go_fetch;
    logic [AW-1:0]    addr_nxt;
    logic             neg_nxt;

    sine_phase_acc #(
        .DEPTH   (DEPTH),
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .step        (step),
        .load_tune   (load_tune),
        .tuning_word (tuning_word),
        .addr_nxt    (addr_nxt),
        .neg_nxt     (neg_nxt)
    );

    always_comb begin
        state_d       = state_q;
        rom_en_d      = 1'b0;
        rom_address_d = rom_address_q;
        sample_d      = sample_q;
        valid_d       = valid_q;
        stop_pend_d   = stop_pend_q;
        neg_d         = neg_q;
        clear         = 1'b0;
        step          = 1'b0;
        load_tune     = 1'b0;
        go_fetch      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    load_tune = 1'b1;
                    go_fetch  = 1'b1;
                end
            end
            FETCH: begin
                stop_pend_d = stop_pend_q | stop;
                state_d     = WAIT;
            end
            WAIT: begin
                stop_pend_d = stop_pend_q | stop;
                sample_d    = neg_q ? (-rom_data) : rom_data;
                valid_d     = 1'b1;
                step        = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                stop_pend_d = stop_pend_q | stop;
                if (valid_q && sample_ready) begin
                    valid_d   = 1'b0;
                    load_tune = 1'b1;
                    if (stop_pend_q || stop) begin
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        go_fetch = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: load them on the edge entering FETCH.
        if (go_fetch) begin
            state_d       = FETCH;
            rom_en_d      = 1'b1;
            rom_address_d = addr_nxt;
            neg_d         = neg_nxt;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rom_en_q      <= 1'b0;
            rom_address_q <= '0;
            sample_q      <= '0;
            valid_q       <= 1'b0;
            stop_pend_q   <= 1'b0;
            neg_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_en_q      <= rom_en_d;
            rom_address_q <= rom_address_d;
            sample_q      <= sample_d;
            valid_q       <= valid_d;
            stop_pend_q   <= stop_pend_d;
            neg_q         <= neg_d;
            busy_q        <= busy_d;
        end
    end

    assign rom_en       = rom_en_q;
    assign rom_address  = rom_address_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sine_rom_sequencer.sv
// Directed bench for sine_rom_sequencer with a registered-read ROM model.
// Covers latency, wrap, backpressure/retune, stop, async reset, quarter wave.
module tb_sine_rom_sequencer;
    import sine_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] tuning_word = '0;
    logic        rom_en;
    logic [5:0]  rom_address;
    logic [31:0] rom_data = '0;
    logic [31:0] sample;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [31:0] mem [64];

    sine_rom_sequencer #(
        .WIDTH   (32),
        .DEPTH   (64),
        .PHASE_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .tuning_word  (tuning_word),
        .rom_en       (rom_en),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One FETCH/WAIT/HOLD step; caller has set start or sample_ready.
    task automatic run_sample(input int a, input int s);
        tick();
        start = 1'b0;
        chk("fetch_en", 32'(rom_en), 32'd1);
        chk("fetch_addr", 32'(rom_address), 32'(a));
        chk("fetch_busy", 32'(busy), 32'd1);
        tick();
        chk("wait_en", 32'(rom_en), 32'd0);
        chk("wait_valid", 32'(sample_valid), 32'd0);
        tick();
        chk("hold_valid", 32'(sample_valid), 32'd1);
        chk("hold_sample", sample, 32'(s));
    endtask

    initial begin
`ifdef SINE_QUARTER_WAVE_EN
        for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);
`else
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("rst_en", 32'(rom_en), 32'd0);
        chk("rst_addr", 32'(rom_address), 32'd0);
        chk("rst_sample", sample, 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

`ifdef SINE_QUARTER_WAVE_EN
        tuning_word  = 16'h0100;
        sample_ready = 1'b1;
        start        = 1'b1;
        for (int n = 0; n <= 192; n++) begin
            int q, idx, a, s;
            q   = (n / 64) % 4;
            idx = n % 64;
            a   = (q % 2 == 1) ? 63 - idx : idx;
            s   = (q >= 2) ? -(a + 1) : (a + 1);
            run_sample(a, s);
        end
`else
        // Table read, latency and wrap-around.
        tuning_word  = 16'h0400;
        sample_ready = 1'b1;
        start        = 1'b1;
        run_sample(0, 0);
        for (int n = 1; n <= 65; n++) begin
            run_sample(n % 64, n % 64);
        end

        // Backpressure with a retune during the stall.
        sample_ready = 1'b0;
        tuning_word  = 16'h0800;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(sample_valid), 32'd1);
            chk("stall_sample", sample, 32'd1);
            chk("stall_en", 32'(rom_en), 32'd0);
        end
        sample_ready = 1'b1;
        run_sample(2, 2);
        run_sample(4, 4);

        // Stop during WAIT; start pulses while busy are ignored.
        tick();
        chk("stop_fetch_addr", 32'(rom_address), 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_en", 32'(rom_en), 32'd0);
        chk("busy_start_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", 32'(sample_valid), 32'd1);
        chk("stop_sample", sample, 32'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stop_idle_busy", 32'(busy), 32'd0);
        chk("stop_idle_valid", 32'(sample_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_en", 32'(rom_en), 32'd0);
            chk("idle_busy2", 32'(busy), 32'd0);
        end

        // Asynchronous reset while holding a valid sample.
        tuning_word = 16'h0400;
        start       = 1'b1;
        run_sample(0, 0);
        run_sample(1, 1);
        sample_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(sample_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(sample_valid), 32'd0);
        chk("arst_sample", sample, 32'd0);
        chk("arst_en", 32'(rom_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #3 rst_n = 1'b1;
        sample_ready = 1'b1;
        start        = 1'b1;
        run_sample(0, 0);
        run_sample(1, 1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sine_rom_sequencer.md
Name: sine_rom_sequencer

Overview:
- Read-side controller for the synchronous sine-table ROM in the sine-wave project.
- Phase accumulator (DDS style) whose upper bits drive the ROM `en`/`address` port.
- Absorbs the ROM's one-cycle registered read latency.
- Delivers each table sample downstream over a valid/ready handshake, at a programmable frequency set by a tuning word.

Parameters:
- WIDTH, 32: ROM data / sample width, two's complement.
- DEPTH, 64: ROM entries; power of two.
- PHASE_W, 16: phase accumulator width; must be ≥ $clog2(DEPTH) (≥ $clog2(DEPTH)+2 with QUARTER_WAVE_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begins generation from phase 0.
- stop  in  1  one-cycle pulse; ends generation after the in-flight sample.
- tuning_word  in  PHASE_W  phase increment per sample.
- rom_en  out  1  ROM read enable.
- rom_address  out  $clog2(DEPTH)  ROM read address.
- rom_data  in  WIDTH  ROM registered read data.
- sample  out  WIDTH  current sample.
- sample_valid  out  1  sample holds valid data.
- sample_ready  in  1  downstream accepts sample.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM = IDLE; phase = 0; tuning register = 0; stop_pend = 0.
  - rom_en = 0, rom_address = 0, sample = 0, sample_valid = 0, busy = 0.
  - Takes effect immediately in any state; an in-flight sample is discarded.
- State IDLE:
  - start=1: phase ← 0, tune ← tuning_word, go to FETCH.
  - stop is ignored in IDLE; start+stop in the same cycle → start wins.
- State FETCH (1 cycle):
  - rom_en = 1, rom_address = phase[PHASE_W-1 -: AW], where AW = $clog2(DEPTH).
  - Unconditionally go to WAIT.
- State WAIT (1 cycle):
  - rom_en = 0; rom_data is valid this cycle.
  - At the end of the cycle: sample ← rom_data, sample_valid ← 1, phase ← phase + tune (modulo 2^PHASE_W), go to HOLD.
- State HOLD:
  - sample and sample_valid stay stable until sample_valid && sample_ready.
  - On handshake: sample_valid ← 0, tune ← tuning_word (a new word applies from the next step on); then go to IDLE if stop_pend or stop this cycle, otherwise go to FETCH.
- Outputs outside FETCH: rom_en = 0 and rom_address holds its last value.
- Latency and throughput:
  - start → first sample_valid = 3 cycles.
  - Peak rate = 1 sample / 3 cycles with sample_ready tied high.
- stop handling:
  - Asserted in FETCH, WAIT or HOLD: sets stop_pend.
  - The pending sample is still delivered and handshaked; the FSM then goes to IDLE and stop_pend clears.
- start while busy: ignored.
- Wrap-around: the phase adder discards carry-out, so the address wraps DEPTH-1 → 0 seamlessly.
- tuning_word = 0: the same address repeats indefinitely. This is legal.
- busy = 1 in FETCH, WAIT and HOLD.

Optional Feature:
- Macro: SINE_QUARTER_WAVE_EN.
- Defined: the ROM holds one quarter period (0..π/2, non-negative values).
  - q = phase[PHASE_W-1:PHASE_W-2], idx = phase[PHASE_W-3 -: AW].
  - rom_address = q[0] ? DEPTH-1-idx : idx.
  - sample ← q[1] ? -rom_data : rom_data (two's-complement negate, computed in the WAIT cycle).
  - The quadrant bits are pipelined from FETCH to WAIT.
- Undefined: the ROM holds a full period; no mirroring or negation; behaviour exactly as above.

Decomposition:
- Package sine_pkg:
  - FSM state enum {IDLE, FETCH, WAIT, HOLD}.
  - Default width constants.
  - Function addr_w(depth) = $clog2(depth).
- Sub-module sine_phase_acc: phase register, tuning register, and address/quadrant extraction.
  - Isolates the SINE_QUARTER_WAVE_EN mapping from the FSM.

Test Plan:
- Table read and latency:
  - Stimulus: ROM mem[i]=i, DEPTH=64, PHASE_W=16, tuning_word=0x0400, sample_ready=1, start pulse.
  - Required response: rom_en pulses every 3 cycles at addresses 0,1,2…; samples 0,1,2; first sample_valid exactly 3 cycles after start.
- Wrap-around:
  - Stimulus: same setup, run 66 samples.
  - Required response: address 63 followed by 0; sample sequence …62,63,0,1.
- Backpressure and retune:
  - Stimulus: hold sample_ready=0 for 5 cycles during HOLD; change tuning_word to 0x0800 meanwhile.
  - Required response: sample stable and rom_en=0 throughout the stall.
  - After the handshake, the phase step already applied this cycle is still 0x0400; steps of 0x0800 follow.
- Stop and start while busy:
  - Stimulus: stop pulse during WAIT.
  - Required response: that sample is delivered, then IDLE with busy=0 and no further rom_en.
  - Also: a start pulse while busy has no effect.
- Async reset mid-operation:
  - Stimulus: rst_n low during HOLD with sample_valid=1.
  - Required response: sample_valid, sample, rom_en and busy go to 0 immediately without a clock edge; the next start restarts from address 0.
- Quarter wave (SINE_QUARTER_WAVE_EN):
  - Stimulus: tuning_word=0x0100; ROM mem[i]=i+1.
  - Required response:
    - phase 0x4000 → address 63, sample 64.
    - phase 0x8000 → address 0, sample −1 (0xFFFFFFFF).
    - phase 0xC000 → address 63, sample −64.
